// File: rtl/dds_pkg.sv
// Shared definitions for the DDS step recovery block: FSM states and default width.
package dds_pkg;

  localparam int DDS_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } dds_state_t;

endpackage

// File: rtl/dds_step_recovery_if.sv
// Phase-sample in / recovered-step out bundle for dds_step_recovery.
// err_count exists only when DDS_STEP_RECOVERY_ERRCNT_EN is defined.
interface dds_step_recovery_if #(
  parameter int W = 12
);

  logic [W-1:0] phase_in;
  logic         phase_valid;
  logic [W-1:0] step_out;
  logic         locked;
  logic         step_change;
`ifdef DDS_STEP_RECOVERY_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  modport master (
    output phase_in, phase_valid,
    input  step_out, locked, step_change
`ifdef DDS_STEP_RECOVERY_ERRCNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  phase_in, phase_valid,
    output step_out, locked, step_change
`ifdef DDS_STEP_RECOVERY_ERRCNT_EN
    , output err_count
`endif
  );

endinterface

// File: rtl/dds_phase_diff.sv
// Holds the previous phase sample and forms the modulo-2^W difference to the new one.
// o_deltaValid is high only for valid samples that have a primed predecessor.
module dds_phase_diff
  import dds_pkg::*;
#(
  parameter int W = DDS_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_phase,
  input  logic         i_valid,
  output logic [W-1:0] o_delta,
  output logic         o_deltaValid
);

  logic [W-1:0] r_prevPhase;
  logic         r_primed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prevPhase <= '0;
      r_primed    <= 1'b0;
    end else if (i_valid) begin
      r_prevPhase <= i_phase;
      r_primed    <= 1'b1;
    end
  end

  // Wrap-around falls out of the W-bit subtraction.
  assign o_delta      = i_phase - r_prevPhase;
  assign o_deltaValid = i_valid & r_primed;

endmodule

// File: rtl/dds_step_recovery.sv
// Recovers the phase-accumulator step from sampled phase words and reports lock.
// Define DDS_STEP_RECOVERY_ERRCNT_EN to add a saturating lock-loss counter (err_count).
module dds_step_recovery
  import dds_pkg::*;
#(
  parameter int W          = DDS_W,
  parameter int LOCK_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dds_step_recovery_if.slave   bus
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  dds_state_t   r_state, w_nextState;
  logic [W-1:0] r_candidate, w_nextCandidate;
  logic [3:0]   r_count, w_nextCount;
  logic [W-1:0] r_stepOut, w_nextStepOut;
  logic         r_locked, w_nextLocked;
  logic         r_stepChange, w_nextStepChange;

  logic [W-1:0] w_delta;
  logic         w_deltaValid;

  dds_phase_diff #(.W(W)) u_phaseDiff (
    .clk          (clk),
    .reset        (reset),
    .i_phase      (bus.phase_in),
    .i_valid      (bus.phase_valid),
    .o_delta      (w_delta),
    .o_deltaValid (w_deltaValid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_candidate  <= '0;
      r_count      <= '0;
      r_stepOut    <= '0;
      r_locked     <= 1'b0;
      r_stepChange <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_candidate  <= w_nextCandidate;
      r_count      <= w_nextCount;
      r_stepOut    <= w_nextStepOut;
      r_locked     <= w_nextLocked;
      r_stepChange <= w_nextStepChange;
    end
  end

  // Lock is declared on the same sample whose match brings the run up to LOCK_COUNT.
  always_comb begin
    w_nextState      = r_state;
    w_nextCandidate  = r_candidate;
    w_nextCount      = r_count;
    w_nextStepOut    = r_stepOut;
    w_nextLocked     = r_locked;
    w_nextStepChange = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.phase_valid) begin
          w_nextState     = TRACK;
          w_nextCandidate = '0;
          w_nextCount     = '0;
        end
      end

      TRACK: begin
        if (w_deltaValid) begin
          if (w_delta == r_candidate && r_count != 4'd0) begin
            w_nextCount = (r_count >= LOCK_CNT) ? LOCK_CNT : r_count + 4'd1;
          end else begin
            w_nextCandidate = w_delta;
            w_nextCount     = 4'd1;
          end
          if (w_nextCount == LOCK_CNT) begin
            w_nextState   = LOCKED;
            w_nextStepOut = w_nextCandidate;
            w_nextLocked  = 1'b1;
          end
        end
      end

      LOCKED: begin
        if (w_deltaValid && w_delta != r_candidate) begin
          w_nextState      = TRACK;
          w_nextCandidate  = w_delta;
          w_nextCount      = 4'd1;
          w_nextLocked     = 1'b0;
          w_nextStepChange = 1'b1;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign bus.step_out    = r_stepOut;
  assign bus.locked      = r_locked;
  assign bus.step_change = r_stepChange;

`ifdef DDS_STEP_RECOVERY_ERRCNT_EN
  logic [15:0] r_errCount;

  // Every LOCKED->TRACK transition is exactly one step_change pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_errCount <= '0;
    end else if (w_nextStepChange && r_errCount != 16'hFFFF) begin
      r_errCount <= r_errCount + 16'd1;
    end
  end

  assign bus.err_count = r_errCount;
`endif

endmodule

// File: tb/tb_dds_step_recovery.sv
// Scoreboard bench for dds_step_recovery: a run-length model of phase deltas predicts outputs.
module tb_dds_step_recovery;

  localparam int W  = 12;
  localparam int LC = 4;

  typedef struct {
    logic [W-1:0] step;
    logic         locked;
    logic         change;
    logic [15:0]  errCnt;
    string        tag;
  } expect_t;

  logic clk;
  logic reset;

  dds_step_recovery_if #(.W(W)) bus ();

  dds_step_recovery #(.W(W), .LOCK_COUNT(LC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  expect_t sbQueue[$];
  int total = 0;
  int bad   = 0;

  // Reference model: deltas since the last reset, tracked as a run of equal values.
  bit           mPrimed;
  logic [W-1:0] mPrev;
  logic [W-1:0] mRunValue;
  int           mRunLen;
  logic [W-1:0] mStep;
  logic         mLocked;
  logic         mChange;
  int           mErr;

  task automatic modelStep(input bit rst, input bit vld, input logic [W-1:0] ph);
    logic [W-1:0] d;
    mChange = 1'b0;
    if (rst) begin
      mPrimed = 0; mPrev = '0; mRunValue = '0; mRunLen = 0;
      mStep = '0; mLocked = 1'b0; mErr = 0;
    end else if (vld) begin
      if (!mPrimed) begin
        mPrimed = 1;
        mPrev   = ph;
      end else begin
        d     = (ph - mPrev) % (1 << W);
        mPrev = ph;
        if (mRunLen > 0 && d == mRunValue) begin
          mRunLen++;
        end else begin
          if (mLocked) begin
            mChange = 1'b1;
            if (mErr < 16'hFFFF) mErr++;
          end
          mRunValue = d;
          mRunLen   = 1;
        end
        mLocked = (mRunLen >= LC);
        if (mLocked) mStep = mRunValue;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit vld, input logic [W-1:0] ph,
                               input string tag);
    expect_t e;
    @(negedge clk);
    reset           = rst;
    bus.phase_valid = vld;
    bus.phase_in    = ph;
    modelStep(rst, vld, ph);
    e.step   = mStep;
    e.locked = mLocked;
    e.change = mChange;
    e.errCnt = 16'(mErr);
    e.tag    = tag;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    bit ok;
    ok = (bus.step_out === e.step) && (bus.locked === e.locked) &&
         (bus.step_change === e.change);
`ifdef DDS_STEP_RECOVERY_ERRCNT_EN
    ok = ok && (bus.err_count === e.errCnt);
    if (!ok)
      $display("[TB] FAIL %s: got step=%h locked=%b chg=%b err=%0d, want step=%h locked=%b chg=%b err=%0d",
               e.tag, bus.step_out, bus.locked, bus.step_change, bus.err_count,
               e.step, e.locked, e.change, e.errCnt);
`else
    if (!ok)
      $display("[TB] FAIL %s: got step=%h locked=%b chg=%b, want step=%h locked=%b chg=%b",
               e.tag, bus.step_out, bus.locked, bus.step_change, e.step, e.locked, e.change);
`endif
    total++;
    if (!ok) bad++;
  endtask

  // Monitor: outputs are registered, so each expectation is checked just after its edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbQueue.size() > 0) checkOutput(sbQueue.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, $urandom(), tag);
  endtask

  initial begin
    logic [W-1:0] ph;
    logic [W-1:0] step;
    logic [W-1:0] steps[5];
    int len;

    reset = 1'b1; bus.phase_valid = 1'b0; bus.phase_in = '0;
    applyStimulus(1'b1, 1'b0, '0, "reset");
    applyStimulus(1'b1, 1'b1, 12'h123, "reset_prio");

    $display("[TB] ramp");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 12'(i * 32), "ramp");

    $display("[TB] wrap and step change");
    applyStimulus(1'b1, 1'b0, '0, "reset");
    ph = 12'hF30;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 1'b1, ph, "wrap");
      ph = ph + 12'h0D0;
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, ph, "step_change");
      ph = ph + 12'h200;
    end

    $display("[TB] gaps");
    for (int i = 0; i < 10; i++) begin
      idleCycles($urandom_range(1, 7), "gap_idle");
      applyStimulus(1'b0, 1'b1, ph, "gap_sample");
      ph = ph + 12'h200;
    end

    $display("[TB] reset mid-lock");
    applyStimulus(1'b1, 1'b0, '0, "reset_midlock");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, ph, "relock");
      ph = ph + 12'h200;
    end

    $display("[TB] zero step");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 12'h555, "zero_step");

    $display("[TB] random segments");
    steps[0] = 12'h020; steps[1] = 12'h0D0; steps[2] = 12'h200;
    steps[3] = 12'h7FF; steps[4] = 12'h000;
    for (int seg = 0; seg < 30; seg++) begin
      if (seg == 17) applyStimulus(1'b1, 1'b0, '0, "rand_reset");
      step = ($urandom_range(0, 5) == 5) ? 12'($urandom()) : steps[$urandom_range(0, 4)];
      len  = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3), "rand_idle");
        ph = ph + step;
        applyStimulus(1'b0, 1'b1, ph, "rand");
      end
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 12'($urandom()), "rand_noise");

    $display("[TB] final reset");
    applyStimulus(1'b1, 1'b0, '0, "final_reset");
    applyStimulus(1'b0, 1'b0, '0, "final_idle");

    @(posedge clk);
    #3;
    total++;
    if (sbQueue.size() != 0) begin
      $display("[TB] FAIL drain: got %0d pending, want 0", sbQueue.size());
      bad++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
